mem_port_arbiter: RTL and testbench

- Shares one single-port word memory between the multi-cycle CPU's instruction-fetch path (I) and load/store path (D).
- Serialises accesses through a small FSM, drives the memory port, captures read data and returns one-cycle acks to each requester.
- Sits between the CPU datapath/controller and the unified memory, below the system bridge.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port word memory between the instruction-fetch (I)
// and load/store (D) requesters with a round-robin, one-access-at-a-time FSM.
module mem_port_arbiter #(
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        m_en_q, m_en_d;
    logic        m_we_q, m_we_d;
    logic [3:0]  m_be_q, m_be_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        busy_q, busy_d;

    logic        gnt_d_s;
    logic [3:0]  unused_addr_bits_s;

    assign unused_addr_bits_s = {i_addr[1:0], d_addr[1:0]};

    // State register: every flop clears asynchronously, aborting any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            addr_q       <= 32'd0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            wdata_q      <= 32'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            m_en_q       <= 1'b0;
            m_we_q       <= 1'b0;
            m_be_q       <= 4'd0;
            m_wdata_q    <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_be_q       <= m_be_d;
            m_wdata_q    <= m_wdata_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic: arbitration, request latching and latency counting.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        // D wins when alone, or on contention when I was served last.
        gnt_d_s      = d_req & (~i_req | (last_owner_q == OWN_I));
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = ISSUE;
                    if (gnt_d_s) begin
                        owner_d      = OWN_D;
                        last_owner_d = OWN_D;
                        addr_d       = {d_addr[31:2], 2'b00};
                        we_d         = d_we;
                        be_d         = d_be;
                        wdata_d      = d_wdata;
                    end else begin
                        owner_d      = OWN_I;
                        last_owner_d = OWN_I;
                        addr_d       = {i_addr[31:2], 2'b00};
                        we_d         = 1'b0;
                        be_d         = 4'b1111;
                        wdata_d      = 32'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d = CNT_INIT;
                if (LAT == 1) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WAIT;
                end
            end
            CAPTURE: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: outputs are registered from the upcoming state.
    always_comb begin
        m_en_d    = (state_d == ISSUE);
        m_we_d    = m_en_d & we_d;
        m_be_d    = m_en_d ? be_d : 4'd0;
        m_wdata_d = m_en_d ? wdata_d : 32'd0;
        busy_d    = (state_d != IDLE);
        i_ack_d   = (state_d == DONE) && (owner_d == OWN_I);
        d_ack_d   = (state_d == DONE) && (owner_d == OWN_D);
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if ((state_q == CAPTURE) && !we_q) begin
            if (owner_q == OWN_I) begin
                i_rdata_d = m_rdata;
            end else begin
                d_rdata_d = m_rdata;
            end
        end else begin
            i_rdata_d = i_rdata_q;
            d_rdata_d = d_rdata_q;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_be    = m_be_q;
    assign m_addr  = addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LAT = 1, 3, 4), each
// with a latency-exact memory model that drives garbage outside the valid cycle.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst     [3];
    logic        i_req   [3];
    logic [31:0] i_addr  [3];
    logic [31:0] i_rdata [3];
    logic        i_ack   [3];
    logic        d_req   [3];
    logic        d_we    [3];
    logic [3:0]  d_be    [3];
    logic [31:0] d_addr  [3];
    logic [31:0] d_wdata [3];
    logic [31:0] d_rdata [3];
    logic        d_ack   [3];
    logic        m_en    [3];
    logic        m_we    [3];
    logic [3:0]  m_be    [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [31:0] m_rdata [3];
    logic        busy    [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2408_0005;
        return a ^ 32'hA5A5_0000;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [7:0]  sh   = 8'h00;
        logic [31:0] hold = 32'h0;

        mem_port_arbiter #(.LAT(L)) u_dut (
            .clk(clk), .rst(rst[g]),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_rdata(i_rdata[g]), .i_ack(i_ack[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_rdata(d_rdata[g]), .d_ack(d_ack[g]),
            .m_en(m_en[g]), .m_we(m_we[g]), .m_be(m_be[g]), .m_addr(m_addr[g]),
            .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g]), .busy(busy[g])
        );

        always @(posedge clk) begin
            sh <= {sh[6:0], m_en[g]};
            if (m_en[g]) hold <= m_addr[g];
        end

        assign m_rdata[g] = sh[L-1] ? mem_word(hold) : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int en_n, en_c1, en_c2, ack_n, ack_c, iack_n, iack_c, dack_n, dack_c, n, guard;
    logic [31:0] en_a1, en_a2;
    logic        be_leak;
    logic        seq [8];

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; i_req[k] = 1'b0; i_addr[k] = 32'd0; d_req[k] = 1'b0;
            d_we[k] = 1'b0; d_be[k] = 4'd0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
        end
        tick(); tick();
        check("rst_m_en", 32'(m_en[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_i_rdata", i_rdata[0], 32'd0);
        check("rst_m_addr", m_addr[1], 32'd0);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        tick();

        // LAT=1 fetch
        i_req[0] = 1'b1; i_addr[0] = 32'h0000_3000;
        check("t1_c0_busy", 32'(busy[0]), 32'd0);
        tick();
        check("t1_c1_m_en", 32'(m_en[0]), 32'd1);
        check("t1_c1_m_addr", m_addr[0], 32'h0000_3000);
        check("t1_c1_busy", 32'(busy[0]), 32'd1);
        tick();
        check("t1_c2_busy", 32'(busy[0]), 32'd1);
        check("t1_c2_m_en", 32'(m_en[0]), 32'd0);
        check("t1_c2_i_ack", 32'(i_ack[0]), 32'd0);
        tick();
        check("t1_c3_i_ack", 32'(i_ack[0]), 32'd1);
        check("t1_c3_i_rdata", i_rdata[0], 32'h2408_0005);
        check("t1_c3_busy", 32'(busy[0]), 32'd1);
        i_req[0] = 1'b0;
        tick();
        check("t1_c4_i_ack", 32'(i_ack[0]), 32'd0);
        check("t1_c4_busy", 32'(busy[0]), 32'd0);

        // LAT=3 store
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_be[1] = 4'b0011;
        d_addr[1] = 32'h0000_0013; d_wdata[1] = 32'hDEAD_BEEF;
        tick();
        check("t2_m_en", 32'(m_en[1]), 32'd1);
        check("t2_m_we", 32'(m_we[1]), 32'd1);
        check("t2_m_be", 32'(m_be[1]), 32'h3);
        check("t2_m_addr", m_addr[1], 32'h0000_0010);
        check("t2_m_wdata", m_wdata[1], 32'hDEAD_BEEF);
        en_n = 0; ack_n = 0; ack_c = 0; be_leak = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (m_en[1]) en_n++;
            if (m_we[1] || (m_be[1] != 4'd0)) be_leak = 1'b1;
            if (d_ack[1]) begin ack_n++; ack_c = c; d_req[1] = 1'b0; end
        end
        check("t2_extra_m_en", 32'(en_n), 32'd0);
        check("t2_we_be_leak", 32'(be_leak), 32'd0);
        check("t2_ack_count", 32'(ack_n), 32'd1);
        check("t2_ack_cycle", 32'(ack_c), 32'd5);
        check("t2_d_rdata", d_rdata[1], 32'd0);
        check("t2_busy_end", 32'(busy[1]), 32'd0);

        // LAT=3 contention right after reset: D first
        rst[1] = 1'b1; tick(); rst[1] = 1'b0;
        i_req[1] = 1'b1; i_addr[1] = 32'h0000_0100;
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_be[1] = 4'hF; d_addr[1] = 32'h0000_0044;
        en_n = 0; en_c1 = 0; en_c2 = 0; en_a1 = 32'd0; en_a2 = 32'd0;
        iack_n = 0; iack_c = 0; dack_n = 0; dack_c = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (m_en[1]) begin
                en_n++;
                if (en_n == 1) begin en_c1 = c; en_a1 = m_addr[1]; end
                if (en_n == 2) begin en_c2 = c; en_a2 = m_addr[1]; end
            end
            if (i_ack[1]) begin iack_n++; iack_c = c; i_req[1] = 1'b0; end
            if (d_ack[1]) begin dack_n++; dack_c = c; d_req[1] = 1'b0; end
        end
        check("t3_en_count", 32'(en_n), 32'd2);
        check("t3_en1_cycle", 32'(en_c1), 32'd1);
        check("t3_en1_addr", en_a1, 32'h0000_0044);
        check("t3_en2_cycle", 32'(en_c2), 32'd7);
        check("t3_en2_addr", en_a2, 32'h0000_0100);
        check("t3_d_ack_n", 32'(dack_n), 32'd1);
        check("t3_d_ack_c", 32'(dack_c), 32'd5);
        check("t3_i_ack_n", 32'(iack_n), 32'd1);
        check("t3_i_ack_c", 32'(iack_c), 32'd11);
        check("t3_d_rdata", d_rdata[1], 32'hA5A5_0044);
        check("t3_i_rdata", i_rdata[1], 32'hA5A5_0100);

        // LAT=1 continuous contention: strict alternation
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        i_req[0] = 1'b1; i_addr[0] = 32'h0000_0400;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_be[0] = 4'hF; d_addr[0] = 32'h0000_0800;
        n = 0; guard = 0; be_leak = 1'b0;
        while (n < 8 && guard < 60) begin
            tick();
            guard++;
            if (i_ack[0] && d_ack[0]) be_leak = 1'b1;
            if (i_ack[0] || d_ack[0]) begin
                seq[n] = d_ack[0];
                n++;
            end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        check("t4_ack_total", 32'(n), 32'd8);
        check("t4_double_ack", 32'(be_leak), 32'd0);
        if (n == 8) begin
            check("t4_first_is_d", 32'(seq[0]), 32'd1);
            for (int k = 1; k < 8; k++) check("t4_alternate", 32'(seq[k] ^ seq[k-1]), 32'd1);
        end
        tick(); tick();
        check("t4_busy_end", 32'(busy[0]), 32'd0);
        check("t4_i_rdata", i_rdata[0], 32'hA5A5_0400);
        check("t4_d_rdata", d_rdata[0], 32'hA5A5_0800);

        // LAT=4 reset while in WAIT
        i_req[2] = 1'b1; i_addr[2] = 32'h0000_0300;
        guard = 0;
        while (!i_ack[2] && guard < 12) begin tick(); guard++; end
        check("t5_pre_ack_seen", 32'(i_ack[2]), 32'd1);
        i_req[2] = 1'b0;
        check("t5_pre_rdata", i_rdata[2], 32'hA5A5_0300);
        tick();
        i_req[2] = 1'b1; i_addr[2] = 32'h0000_0200;
        tick(); tick();
        check("t5_wait_busy", 32'(busy[2]), 32'd1);
        rst[2] = 1'b1;
        #1;
        check("t5_rst_m_en", 32'(m_en[2]), 32'd0);
        check("t5_rst_busy", 32'(busy[2]), 32'd0);
        check("t5_rst_i_rdata", i_rdata[2], 32'd0);
        check("t5_rst_m_addr", m_addr[2], 32'd0);
        tick(); tick();
        check("t5_rst_i_ack", 32'(i_ack[2]), 32'd0);
        rst[2] = 1'b0;
        en_c1 = 0; iack_n = 0; iack_c = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (m_en[2] && en_c1 == 0) en_c1 = c;
            if (i_ack[2]) begin iack_n++; iack_c = c; i_req[2] = 1'b0; end
        end
        check("t5_en_cycle", 32'(en_c1), 32'd1);
        check("t5_ack_n", 32'(iack_n), 32'd1);
        check("t5_ack_c", 32'(iack_c), 32'd6);
        check("t5_i_rdata", i_rdata[2], 32'hA5A5_0200);

        // LAT=3 d_req dropped one cycle after grant
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_be[1] = 4'hF; d_addr[1] = 32'h0000_0080;
        tick();
        d_req[1] = 1'b0;
        dack_n = 0; dack_c = 0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            if (d_ack[1]) begin dack_n++; dack_c = c; end
        end
        check("t6_ack_n", 32'(dack_n), 32'd1);
        check("t6_ack_c", 32'(dack_c), 32'd5);
        check("t6_d_rdata", d_rdata[1], 32'hA5A5_0080);
        check("t6_busy_end", 32'(busy[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
